// File: rtl/operator_arbiter_pkg.sv
// Shared encodings for operator_arbiter: FSM states, requester count and grant type.
package operator_arbiter_pkg;

  localparam int NUM_REQUESTERS = 2;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ACCEPT = 3'd1;
  localparam logic [2:0] ISSUE  = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] RETURN = 3'd4;

  typedef logic grant_t;

  // A tie goes to the requester that was not served last.
  function automatic grant_t rr_pick(input logic [NUM_REQUESTERS-1:0] pending,
                                     input grant_t last_grant);
    if (pending[0] && pending[1]) return ~last_grant;
    return pending[1];
  endfunction

endpackage

// File: rtl/operator_arbiter_stream_out_reg.sv
// Registered stb/data source: load raises stb with new data, stb drops the cycle after ack.
module stream_out_reg #(
  parameter int BITS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [BITS-1:0] load_dat,
  output logic [BITS-1:0] dat,
  output logic            stb,
  input  logic            ack
);

  logic            stb_d, stb_q;
  logic [BITS-1:0] dat_d, dat_q;

  always_comb begin
    stb_d = stb_q;
    dat_d = dat_q;
    if (stb_q && ack) stb_d = 1'b0;
    if (load) begin
      stb_d = 1'b1;
      dat_d = load_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stb_q <= 1'b0;
      dat_q <= '0;
    end else begin
      stb_q <= stb_d;
      dat_q <= dat_d;
    end
  end

  assign stb = stb_q;
  assign dat = dat_q;

endmodule

// File: rtl/operator_arbiter.sv
// Shares one two-input stream operator between two requesters, one transaction in flight.
// Build option OPERATOR_ARBITER_STRICT_PRIORITY_EN: requester 0 wins every tie instead of round-robin.
module operator_arbiter #(
  parameter int bits = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] req0_a,
  input  logic            req0_a_stb,
  output logic            req0_a_ack,
  input  logic [bits-1:0] req0_b,
  input  logic            req0_b_stb,
  output logic            req0_b_ack,
  output logic [bits-1:0] res0,
  output logic            res0_stb,
  input  logic            res0_ack,
  input  logic [bits-1:0] req1_a,
  input  logic            req1_a_stb,
  output logic            req1_a_ack,
  input  logic [bits-1:0] req1_b,
  input  logic            req1_b_stb,
  output logic            req1_b_ack,
  output logic [bits-1:0] res1,
  output logic            res1_stb,
  input  logic            res1_ack,
  output logic [bits-1:0] op_a,
  output logic            op_a_stb,
  input  logic            op_a_ack,
  output logic [bits-1:0] op_b,
  output logic            op_b_stb,
  input  logic            op_b_ack,
  input  logic [bits-1:0] op_res,
  input  logic            op_res_stb,
  output logic            op_res_ack
);

  import operator_arbiter_pkg::*;

  logic [2:0]                state_d, state_q;
  grant_t                    grant_d, grant_q, pick;
  logic [NUM_REQUESTERS-1:0] pending;
  logic [NUM_REQUESTERS-1:0] a_ack_d, a_ack_q, b_ack_d, b_ack_q;
  logic                      op_res_ack_d, op_res_ack_q;
  logic                      op_load;
  logic [NUM_REQUESTERS-1:0] res_load;
  logic [bits-1:0]           grant_a, grant_b;
  logic                      res_stb_g, res_ack_g;
  logic                      op_a_done, op_b_done;

  assign pending   = {req1_a_stb & req1_b_stb, req0_a_stb & req0_b_stb};
  assign grant_a   = grant_q ? req1_a : req0_a;
  assign grant_b   = grant_q ? req1_b : req0_b;
  assign res_stb_g = grant_q ? res1_stb : res0_stb;
  assign res_ack_g = grant_q ? res1_ack : res0_ack;
  assign op_a_done = !op_a_stb || op_a_ack;
  assign op_b_done = !op_b_stb || op_b_ack;

`ifdef OPERATOR_ARBITER_STRICT_PRIORITY_EN
  assign pick = pending[0] ? 1'b0 : 1'b1;
`else
  grant_t last_grant_d, last_grant_q;

  assign pick = rr_pick(pending, last_grant_q);

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == RETURN && res_stb_g && res_ack_g) last_grant_d = grant_q;
  end

  // Reset value 1 hands the first tie to requester 0.
  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    op_load  = 1'b0;
    res_load = '0;
    case (state_q)
      IDLE: begin
        if (|pending) begin
          grant_d = pick;
          state_d = ACCEPT;
        end
      end
      ACCEPT: begin
        op_load = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (op_a_done && op_b_done) state_d = WAIT;
      end
      WAIT: begin
        if (op_res_stb && op_res_ack_q) begin
          res_load[grant_q] = 1'b1;
          state_d           = RETURN;
        end
      end
      RETURN: begin
        if (res_stb_g && res_ack_g) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Acks are registered, so they are derived from the state being entered.
    a_ack_d = '0;
    b_ack_d = '0;
    if (state_d == ACCEPT) begin
      a_ack_d[grant_d] = 1'b1;
      b_ack_d[grant_d] = 1'b1;
    end
    op_res_ack_d = (state_d == WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      a_ack_q      <= '0;
      b_ack_q      <= '0;
      op_res_ack_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      op_res_ack_q <= op_res_ack_d;
    end
  end

  assign req0_a_ack = a_ack_q[0];
  assign req0_b_ack = b_ack_q[0];
  assign req1_a_ack = a_ack_q[1];
  assign req1_b_ack = b_ack_q[1];
  assign op_res_ack = op_res_ack_q;

  stream_out_reg #(.BITS(bits)) u_op_a (
    .clk(clk), .rst(rst), .load(op_load), .load_dat(grant_a),
    .dat(op_a), .stb(op_a_stb), .ack(op_a_ack)
  );

  stream_out_reg #(.BITS(bits)) u_op_b (
    .clk(clk), .rst(rst), .load(op_load), .load_dat(grant_b),
    .dat(op_b), .stb(op_b_stb), .ack(op_b_ack)
  );

  stream_out_reg #(.BITS(bits)) u_res0 (
    .clk(clk), .rst(rst), .load(res_load[0]), .load_dat(op_res),
    .dat(res0), .stb(res0_stb), .ack(res0_ack)
  );

  stream_out_reg #(.BITS(bits)) u_res1 (
    .clk(clk), .rst(rst), .load(res_load[1]), .load_dat(op_res),
    .dat(res1), .stb(res1_stb), .ack(res1_ack)
  );

endmodule

// File: tb/tb_operator_arbiter.sv
// Directed bench for operator_arbiter with queued requesters and a behavioural adder operator.
module tb_operator_arbiter;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_a_stb = 1'b0, req0_b_stb = 1'b0, req1_a_stb = 1'b0, req1_b_stb = 1'b0;
  logic         req0_a_ack, req0_b_ack, req1_a_ack, req1_b_ack;
  logic [W-1:0] res0, res1, op_a, op_b;
  logic         res0_stb, res1_stb, op_a_stb, op_b_stb, op_res_ack;
  logic         res0_ack = 1'b1, res1_ack = 1'b1;
  logic         op_a_ack = 1'b0, op_b_ack = 1'b0, op_res_stb = 1'b0;
  logic [W-1:0] op_res = '0;

  operator_arbiter #(.bits(W)) dut (
    .clk(clk), .rst(rst),
    .req0_a(req0_a), .req0_a_stb(req0_a_stb), .req0_a_ack(req0_a_ack),
    .req0_b(req0_b), .req0_b_stb(req0_b_stb), .req0_b_ack(req0_b_ack),
    .res0(res0), .res0_stb(res0_stb), .res0_ack(res0_ack),
    .req1_a(req1_a), .req1_a_stb(req1_a_stb), .req1_a_ack(req1_a_ack),
    .req1_b(req1_b), .req1_b_stb(req1_b_stb), .req1_b_ack(req1_b_ack),
    .res1(res1), .res1_stb(res1_stb), .res1_ack(res1_ack),
    .op_a(op_a), .op_a_stb(op_a_stb), .op_a_ack(op_a_ack),
    .op_b(op_b), .op_b_stb(op_b_stb), .op_b_ack(op_b_ack),
    .op_res(op_res), .op_res_stb(op_res_stb), .op_res_ack(op_res_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Requester model: each queue entry is presented on both operand streams until acked.
  logic [W-1:0] qa [2][64];
  logic [W-1:0] qb [2][64];
  int   q_tail [2] = '{0, 0};
  int   q_head [2] = '{0, 0};
  logic r_stb  [2] = '{1'b0, 1'b0};
  logic r_done [2] = '{1'b0, 1'b0};
  logic r1_b_block = 1'b0;
  logic [1:0] r_a_ack, r_b_ack;
  assign r_a_ack = {req1_a_ack, req0_a_ack};
  assign r_b_ack = {req1_b_ack, req0_b_ack};

  always @(negedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (rst) begin
        q_head[r] = q_tail[r];
        r_stb[r]  = 1'b0;
        r_done[r] = 1'b0;
      end else begin
        if (r_done[r]) begin
          r_done[r] = 1'b0;
          r_stb[r]  = 1'b0;
          q_head[r] = q_head[r] + 1;
        end
        if (!r_stb[r] && q_head[r] != q_tail[r]) r_stb[r] = 1'b1;
        if (r_stb[r] && r_a_ack[r] && r_b_ack[r]) r_done[r] = 1'b1;
      end
    end
    req0_a     = qa[0][q_head[0][5:0]];
    req0_b     = qb[0][q_head[0][5:0]];
    req1_a     = qa[1][q_head[1][5:0]];
    req1_b     = qb[1][q_head[1][5:0]];
    req0_a_stb = r_stb[0];
    req0_b_stb = r_stb[0];
    req1_a_stb = r_stb[1];
    req1_b_stb = r_stb[1] & ~r1_b_block;
  end

  task automatic push(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    qa[r][q_tail[r][5:0]] = a;
    qb[r][q_tail[r][5:0]] = b;
    q_tail[r] = q_tail[r] + 1;
  endtask

  // Behavioural adder with programmable ack and result delays.
  int a_dly = 0, b_dly = 0, r_dly = 0;
  int a_cnt = 0, b_cnt = 0, r_cnt = 0;
  logic got_a = 1'b0, got_b = 1'b0, res_xfer = 1'b0;
  logic [W-1:0] opa_v = '0, opb_v = '0;

  always @(negedge clk) begin
    if (rst) begin
      op_a_ack = 1'b0; op_b_ack = 1'b0; op_res_stb = 1'b0; op_res = '0;
      got_a = 1'b0; got_b = 1'b0; res_xfer = 1'b0;
      a_cnt = 0; b_cnt = 0; r_cnt = 0;
    end else begin
      if (res_xfer) begin
        op_res_stb = 1'b0; got_a = 1'b0; got_b = 1'b0; r_cnt = 0; res_xfer = 1'b0;
      end else if (got_a && got_b) begin
        if (r_cnt >= r_dly) begin
          op_res_stb = 1'b1;
          op_res     = opa_v + opb_v;
        end
        r_cnt++;
        res_xfer = op_res_stb & op_res_ack;
      end
      if (op_a_stb && !got_a) begin
        op_a_ack = (a_cnt >= a_dly);
        a_cnt++;
        if (op_a_ack) begin got_a = 1'b1; opa_v = op_a; a_cnt = 0; end
      end else op_a_ack = 1'b0;
      if (op_b_stb && !got_b) begin
        op_b_ack = (b_cnt >= b_dly);
        b_cnt++;
        if (op_b_ack) begin got_b = 1'b1; opb_v = op_b; b_cnt = 0; end
      end else op_b_ack = 1'b0;
    end
  end

  // Result log: value, requester and cycle of every accepted result word.
  logic [W-1:0] log_v [64];
  int log_g [64];
  int log_c [64];
  int lc = 0, a_hi = 0, b_hi = 0, viol = 0;

  always @(negedge clk) begin
    if (res0_stb && res0_ack) begin
      log_v[lc[5:0]] = res0; log_g[lc[5:0]] = 0; log_c[lc[5:0]] = cyc; lc++;
    end
    if (res1_stb && res1_ack) begin
      log_v[lc[5:0]] = res1; log_g[lc[5:0]] = 1; log_c[lc[5:0]] = cyc; lc++;
    end
    if (op_a_stb) a_hi++;
    if (op_b_stb) b_hi++;
    if (op_res_ack && (op_a_stb || op_b_stb)) viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    res0_ack = 1'b1; res1_ack = 1'b1; r1_b_block = 1'b0;
    a_dly = 0; b_dly = 0; r_dly = 0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({op_a_stb, op_b_stb, res0_stb, res1_stb} !== 4'b0) begin
      n_bad++; $display("FAIL reset_stb: got %b want 0000", {op_a_stb, op_b_stb, res0_stb, res1_stb});
    end
    n_cmp++;
    if ({req0_a_ack, req0_b_ack, req1_a_ack, req1_b_ack, op_res_ack} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ack: got %b want 00000",
                        {req0_a_ack, req0_b_ack, req1_a_ack, req1_b_ack, op_res_ack});
    end
    n_cmp++;
    if ({res0, res1, op_a, op_b} !== 64'd0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", {res0, res1, op_a, op_b});
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int k, base;
    logic seen1;
    do_reset();
    base = lc; seen1 = 1'b0; k = 0;
    push(0, 16'd3, 16'd4);
    while (k < 20 && res0_stb !== 1'b1) begin
      tick(); k++;
      seen1 |= req1_a_ack | req1_b_ack;
    end
    n_cmp++;
    if (k !== 4) begin n_bad++; $display("FAIL single_latency: got %0d want 4", k); end
    n_cmp++;
    if (res0 !== 16'd7) begin n_bad++; $display("FAIL single_res0: got %0d want 7", res0); end
    for (int i = 0; i < 20 && lc == base; i++) tick();
    n_cmp++;
    if (lc - base !== 1 || log_g[base[5:0]] !== 0) begin
      n_bad++; $display("FAIL single_log: got count %0d req %0d want 1 req 0", lc - base, log_g[base[5:0]]);
    end
    n_cmp++;
    if (seen1 !== 1'b0) begin n_bad++; $display("FAIL single_req1_ack: got %b want 0", seen1); end
  endtask

  task automatic test_both_pending();
    int base, j;
    do_reset();
    base = lc;
    push(0, 16'd10, 16'd2);
    push(1, 16'd5, 16'd5);
    for (int i = 0; i < 60 && lc < base + 2; i++) tick();
    j = base + 1;
    n_cmp++;
    if (lc !== base + 2) begin n_bad++; $display("FAIL both_count: got %0d want 2", lc - base); end
    n_cmp++;
    if (log_v[base[5:0]] !== 16'd12 || log_g[base[5:0]] !== 0) begin
      n_bad++; $display("FAIL both_first: got %0d from req %0d want 12 from req 0", log_v[base[5:0]], log_g[base[5:0]]);
    end
    n_cmp++;
    if (log_v[j[5:0]] !== 16'd10 || log_g[j[5:0]] !== 1) begin
      n_bad++; $display("FAIL both_second: got %0d from req %0d want 10 from req 1", log_v[j[5:0]], log_g[j[5:0]]);
    end
  endtask

  task automatic test_back_to_back();
    int base, j;
    logic [W-1:0] ev [8];
    int eg [8];
`ifdef OPERATOR_ARBITER_STRICT_PRIORITY_EN
    ev = '{16'd2, 16'd4, 16'd6, 16'd8, 16'd10, 16'd20, 16'd30, 16'd40};
    eg = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    ev = '{16'd2, 16'd10, 16'd4, 16'd20, 16'd6, 16'd30, 16'd8, 16'd40};
    eg = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    do_reset();
    base = lc;
    for (int i = 1; i <= 4; i++) begin
      push(0, 16'(i), 16'(i));
      push(1, 16'(i * 10), 16'd0);
    end
    for (int i = 0; i < 200 && lc < base + 8; i++) tick();
    n_cmp++;
    if (lc !== base + 8) begin n_bad++; $display("FAIL b2b_count: got %0d want 8", lc - base); end
    for (int i = 0; i < 8; i++) begin
      j = base + i;
      n_cmp++;
      if (log_v[j[5:0]] !== ev[i] || log_g[j[5:0]] !== eg[i]) begin
        n_bad++; $display("FAIL b2b_result[%0d]: got %0d from req %0d want %0d from req %0d",
                          i, log_v[j[5:0]], log_g[j[5:0]], ev[i], eg[i]);
      end
      if (i > 0) begin
        n_cmp++;
        if (log_c[j[5:0]] - log_c[(j - 1) & 63] !== 5) begin
          n_bad++; $display("FAIL b2b_spacing[%0d]: got %0d want 5", i, log_c[j[5:0]] - log_c[(j - 1) & 63]);
        end
      end
    end
  endtask

  task automatic test_operator_stall();
    int base, a0, b0, v0;
    do_reset();
    a_dly = 3; b_dly = 1; r_dly = 6;
    base = lc; a0 = a_hi; b0 = b_hi; v0 = viol;
    push(0, 16'd100, 16'd23);
    for (int i = 0; i < 100 && lc == base; i++) tick();
    n_cmp++;
    if (lc !== base + 1 || log_v[base[5:0]] !== 16'd123) begin
      n_bad++; $display("FAIL stall_result: got %0d (count %0d) want 123", log_v[base[5:0]], lc - base);
    end
    n_cmp++;
    if (a_hi - a0 !== 4) begin n_bad++; $display("FAIL stall_op_a_stb_cycles: got %0d want 4", a_hi - a0); end
    n_cmp++;
    if (b_hi - b0 !== 2) begin n_bad++; $display("FAIL stall_op_b_stb_cycles: got %0d want 2", b_hi - b0); end
    n_cmp++;
    if (viol - v0 !== 0) begin n_bad++; $display("FAIL stall_res_ack_early: got %0d want 0", viol - v0); end
  endtask

  task automatic test_partial_request();
    int base, k, j;
    logic seen1;
    do_reset();
    r1_b_block = 1'b1;
    base = lc; seen1 = 1'b0;
    push(1, 16'd9, 16'd1);
    push(0, 16'd3, 16'd3);
    repeat (20) begin
      tick();
      seen1 |= req1_a_ack | req1_b_ack;
    end
    n_cmp++;
    if (seen1 !== 1'b0) begin n_bad++; $display("FAIL partial_req1_ack: got %b want 0", seen1); end
    n_cmp++;
    if (lc !== base + 1 || log_v[base[5:0]] !== 16'd6) begin
      n_bad++; $display("FAIL partial_req0: got %0d (count %0d) want 6", log_v[base[5:0]], lc - base);
    end
    r1_b_block = 1'b0;
    k = 0;
    while (k < 20 && res1_stb !== 1'b1) begin tick(); k++; end
    n_cmp++;
    if (k !== 4) begin n_bad++; $display("FAIL partial_grant_latency: got %0d want 4", k); end
    for (int i = 0; i < 20 && lc < base + 2; i++) tick();
    j = base + 1;
    n_cmp++;
    if (log_v[j[5:0]] !== 16'd10 || log_g[j[5:0]] !== 1) begin
      n_bad++; $display("FAIL partial_req1: got %0d from req %0d want 10 from req 1", log_v[j[5:0]], log_g[j[5:0]]);
    end
  endtask

  task automatic test_consumer_stall();
    int base, k, j;
    logic seen1;
    do_reset();
    res0_ack = 1'b0;
    base = lc; seen1 = 1'b0; k = 0;
    push(0, 16'd20, 16'd22);
    push(1, 16'd1, 16'd2);
    while (k < 20 && res0_stb !== 1'b1) begin tick(); k++; end
    for (int i = 0; i < 10; i++) begin
      tick();
      seen1 |= req1_a_ack | req1_b_ack;
      n_cmp++;
      if ({res0_stb, res0} !== {1'b1, 16'd42}) begin
        n_bad++; $display("FAIL cstall_hold[%0d]: got stb %b data %0d want stb 1 data 42", i, res0_stb, res0);
      end
    end
    n_cmp++;
    if (seen1 !== 1'b0 || lc !== base) begin
      n_bad++; $display("FAIL cstall_other: got req1 ack %b log count %0d want 0 and 0", seen1, lc - base);
    end
    res0_ack = 1'b1;
    for (int i = 0; i < 40 && lc < base + 2; i++) tick();
    j = base + 1;
    n_cmp++;
    if (log_v[base[5:0]] !== 16'd42 || log_v[j[5:0]] !== 16'd3 || log_g[j[5:0]] !== 1 || lc !== base + 2) begin
      n_bad++; $display("FAIL cstall_release: got %0d,%0d req %0d count %0d want 42,3 req 1 count 2",
                        log_v[base[5:0]], log_v[j[5:0]], log_g[j[5:0]], lc - base);
    end
  endtask

  task automatic test_reset_mid_issue();
    int base, k, j;
    do_reset();
    a_dly = 5;
    k = 0;
    push(0, 16'd100, 16'd1);
    while (k < 20 && op_a_stb !== 1'b1) begin tick(); k++; end
    tick();
    n_cmp++;
    if (op_a_stb !== 1'b1) begin n_bad++; $display("FAIL midrst_setup: got op_a_stb %b want 1", op_a_stb); end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({op_a_stb, op_b_stb, res0_stb, res1_stb, req0_a_ack, req0_b_ack,
         req1_a_ack, req1_b_ack, op_res_ack} !== 9'b0) begin
      n_bad++; $display("FAIL midrst_handshake: got %b want 000000000",
                        {op_a_stb, op_b_stb, res0_stb, res1_stb, req0_a_ack, req0_b_ack,
                         req1_a_ack, req1_b_ack, op_res_ack});
    end
    n_cmp++;
    if ({op_a, op_b, res0, res1} !== 64'd0) begin
      n_bad++; $display("FAIL midrst_data: got %h want 0", {op_a, op_b, res0, res1});
    end
    rst = 1'b0;
    a_dly = 0;
    base = lc;
    push(0, 16'd7, 16'd8);
    push(1, 16'd1, 16'd1);
    for (int i = 0; i < 60 && lc < base + 2; i++) tick();
    j = base + 1;
    n_cmp++;
    if (lc !== base + 2 || log_v[base[5:0]] !== 16'd15 || log_g[base[5:0]] !== 0) begin
      n_bad++; $display("FAIL midrst_fresh: got %0d from req %0d count %0d want 15 from req 0 count 2",
                        log_v[base[5:0]], log_g[base[5:0]], lc - base);
    end
    n_cmp++;
    if (log_v[j[5:0]] !== 16'd2 || log_g[j[5:0]] !== 1) begin
      n_bad++; $display("FAIL midrst_second: got %0d from req %0d want 2 from req 1", log_v[j[5:0]], log_g[j[5:0]]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_both_pending();
    test_back_to_back();
    test_operator_stall();
    test_partial_request();
    test_consumer_stall();
    test_reset_mid_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
